// File: rtl/hp_wind_ctl.sv
// HP/wind game-state source for the VGA overlay: tracks both players' HP and the wind and flags end of game.
// Define HP_WIND_RANDOM_EN to draw wind from a 16-bit LFSR; otherwise wind follows a deterministic step.
module hp_wind_ctl #(
    parameter logic [6:0]  HP_MAX    = 7'd100,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk60MHz,
    input  logic       rst,
    input  logic       new_game,
    input  logic       hit_p1,
    input  logic       hit_p2,
    input  logic [6:0] damage,
    input  logic       turn_end,
    output logic [6:0] hp_player1,
    output logic [6:0] hp_player2,
    output logic [2:0] wind,
    output logic       game_over,
    output logic [1:0] winner
);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        OVER
    } state_t;

    state_t     state_q;
    logic [6:0] hp1_q, hp2_q;
    logic [6:0] hp1_d, hp2_d;
    logic [2:0] wind_q;
    logic       game_over_q;
    logic [1:0] winner_q;
    logic [2:0] wind_new_game;
    logic [2:0] wind_turn;

    // Compare one bit wider than the operands so a large hit clamps at zero instead of wrapping.
    function automatic logic [6:0] sat_sub(input logic [6:0] hp, input logic [6:0] dmg);
        return ({1'b0, dmg} >= {1'b0, hp}) ? 7'd0 : (hp - dmg);
    endfunction

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        hp1_d = hp1_q;
        hp2_d = hp2_q;
        if (hit_p1) hp1_d = sat_sub(hp1_q, damage);
        if (hit_p2) hp2_d = sat_sub(hp2_q, damage);
    end

`ifdef HP_WIND_RANDOM_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    // Wind is taken from the pre-shift LFSR value of the loading cycle.
    assign wind_new_game = lfsr_q[2:0];
    assign wind_turn     = lfsr_q[2:0];
`else
    assign wind_new_game = 3'b000;
    // Magnitude counts mod 4; the direction flips each time it wraps from 3 back to 0.
    assign wind_turn     = {wind_q[2] ^ (&wind_q[1:0]), wind_q[1:0] + 2'd1};
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            state_q     <= IDLE;
            hp1_q       <= HP_MAX;
            hp2_q       <= HP_MAX;
            wind_q      <= 3'b000;
            game_over_q <= 1'b0;
            winner_q    <= 2'b00;
        end else begin
            case (state_q)
                IDLE, OVER: begin
                    if (new_game) begin
                        state_q     <= PLAY;
                        hp1_q       <= HP_MAX;
                        hp2_q       <= HP_MAX;
                        wind_q      <= wind_new_game;
                        game_over_q <= 1'b0;
                        winner_q    <= 2'b00;
                    end
                end
                PLAY: begin
                    if (new_game) begin
                        hp1_q       <= HP_MAX;
                        hp2_q       <= HP_MAX;
                        wind_q      <= wind_new_game;
                        game_over_q <= 1'b0;
                        winner_q    <= 2'b00;
                    end else begin
                        hp1_q <= hp1_d;
                        hp2_q <= hp2_d;
                        if (turn_end) wind_q <= wind_turn;
                        // Game ends on the same edge that writes a zero HP; winner is the survivor.
                        if ((hp1_d == 7'd0) || (hp2_d == 7'd0)) begin
                            state_q     <= OVER;
                            game_over_q <= 1'b1;
                            winner_q    <= {hp1_d == 7'd0, hp2_d == 7'd0};
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign hp_player1 = hp1_q;
    assign hp_player2 = hp2_q;
    assign wind       = wind_q;
    assign game_over  = game_over_q;
    assign winner     = winner_q;

endmodule

// File: tb/tb_hp_wind_ctl.sv
// Directed bench for hp_wind_ctl: hand-computed HP, wind, game_over and winner after each event.
// Wind sequence checks apply to the deterministic build; the LFSR build checks only the first wind load.
module tb_hp_wind_ctl;

    logic       clk60MHz = 1'b0;
    logic       rst      = 1'b1;
    logic       new_game = 1'b0;
    logic       hit_p1   = 1'b0;
    logic       hit_p2   = 1'b0;
    logic [6:0] damage   = 7'd0;
    logic       turn_end = 1'b0;
    logic [6:0] hp_player1;
    logic [6:0] hp_player2;
    logic [2:0] wind;
    logic       game_over;
    logic [1:0] winner;

    int n_tests = 0;
    int n_fail  = 0;

    hp_wind_ctl dut (
        .clk60MHz  (clk60MHz),
        .rst       (rst),
        .new_game  (new_game),
        .hit_p1    (hit_p1),
        .hit_p2    (hit_p2),
        .damage    (damage),
        .turn_end  (turn_end),
        .hp_player1(hp_player1),
        .hp_player2(hp_player2),
        .wind      (wind),
        .game_over (game_over),
        .winner    (winner)
    );

    always #8 clk60MHz = ~clk60MHz;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1 time unit later, then drop all one-cycle pulses.
    task automatic step();
        @(posedge clk60MHz);
        #1;
        new_game = 1'b0;
        hit_p1   = 1'b0;
        hit_p2   = 1'b0;
        turn_end = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic [6:0] e_hp1, input logic [6:0] e_hp2,
                             input logic e_go, input logic [1:0] e_win);
        check({tag, ".hp1"},    {1'b0, hp_player1},   {1'b0, e_hp1});
        check({tag, ".hp2"},    {1'b0, hp_player2},   {1'b0, e_hp2});
        check({tag, ".go"},     {7'd0, game_over},    {7'd0, e_go});
        check({tag, ".winner"}, {6'd0, winner},       {6'd0, e_win});
    endtask

    logic [2:0] exp_first_wind;
    logic [2:0] wind_seq [6];

    initial begin
`ifdef HP_WIND_RANDOM_EN
        exp_first_wind = 3'b001;
`else
        exp_first_wind = 3'b000;
`endif
        wind_seq = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};

        // Reset state
        step();
        step();
        check_all("reset", 7'd100, 7'd100, 1'b0, 2'b00);
        check("reset.wind", {5'd0, wind}, 8'd0);

        // new_game on the first cycle after reset release
        rst      = 1'b0;
        new_game = 1'b1;
        step();
        check_all("start", 7'd100, 7'd100, 1'b0, 2'b00);
        check("start.wind", {5'd0, wind}, {5'd0, exp_first_wind});

        // Four hits of 30 on player 1: 70, 40, 10, then saturate at 0
        damage = 7'd30;
        hit_p1 = 1'b1; step(); check_all("p1hit1", 7'd70, 7'd100, 1'b0, 2'b00);
        hit_p1 = 1'b1; step(); check_all("p1hit2", 7'd40, 7'd100, 1'b0, 2'b00);
        hit_p1 = 1'b1; step(); check_all("p1hit3", 7'd10, 7'd100, 1'b0, 2'b00);
        hit_p1 = 1'b1; step(); check_all("p1hit4", 7'd0,  7'd100, 1'b1, 2'b10);

        // Hit in OVER is ignored
        hit_p2 = 1'b1; step(); check_all("over_hit", 7'd0, 7'd100, 1'b1, 2'b10);

        // new_game with simultaneous hit from OVER: restart, hit ignored
        new_game = 1'b1;
        hit_p2   = 1'b1;
        step();
        check_all("restart", 7'd100, 7'd100, 1'b0, 2'b00);

`ifndef HP_WIND_RANDOM_EN
        // Deterministic wind steps
        check("ws.start", {5'd0, wind}, 8'd0);
        for (int i = 0; i < 6; i++) begin
            turn_end = 1'b1;
            step();
            check($sformatf("ws%0d", i), {5'd0, wind}, {5'd0, wind_seq[i]});
        end
`endif

        // Both to 20, then a simultaneous killing hit -> draw
        damage = 7'd80; hit_p1 = 1'b1; hit_p2 = 1'b1; step();
        check_all("both20", 7'd20, 7'd20, 1'b0, 2'b00);
        damage = 7'd20; hit_p1 = 1'b1; hit_p2 = 1'b1; step();
        check_all("draw", 7'd0, 7'd0, 1'b1, 2'b11);

        // 55/80, zero damage, then reset mid-game
        new_game = 1'b1; step();
        damage = 7'd45; hit_p1 = 1'b1; step();
        damage = 7'd20; hit_p2 = 1'b1; step();
        check_all("hp55_80", 7'd55, 7'd80, 1'b0, 2'b00);
        damage = 7'd0; hit_p1 = 1'b1; hit_p2 = 1'b1; step();
        check_all("zero_dmg", 7'd55, 7'd80, 1'b0, 2'b00);
        rst = 1'b1; hit_p1 = 1'b1; damage = 7'd10; step();
        rst = 1'b0;
        check_all("midrst", 7'd100, 7'd100, 1'b0, 2'b00);
        check("midrst.wind", {5'd0, wind}, 8'd0);
        damage = 7'd10; hit_p1 = 1'b1; step();
        check_all("idle_hit", 7'd100, 7'd100, 1'b0, 2'b00);

        // Oversized hit on player 2 together with turn_end: game ends, wind still moves
        new_game = 1'b1; step();
        damage = 7'd127; hit_p2 = 1'b1; turn_end = 1'b1; step();
        check_all("p2kill", 7'd100, 7'd0, 1'b1, 2'b01);
`ifndef HP_WIND_RANDOM_EN
        check("p2kill.wind", {5'd0, wind}, 8'd1);
`endif

        // new_game in PLAY overrides a simultaneous hit and turn_end
        new_game = 1'b1; step();
        damage = 7'd10; hit_p1 = 1'b1; turn_end = 1'b1; step();
        check_all("play_hit", 7'd90, 7'd100, 1'b0, 2'b00);
        new_game = 1'b1; hit_p1 = 1'b1; turn_end = 1'b1; step();
        check_all("override", 7'd100, 7'd100, 1'b0, 2'b00);
`ifndef HP_WIND_RANDOM_EN
        check("override.wind", {5'd0, wind}, 8'd0);
`endif

        // Held hit pulse counts once per cycle
        damage = 7'd40; hit_p2 = 1'b1;
        @(posedge clk60MHz); #1;
        check("hold1.hp2", {1'b0, hp_player2}, 8'd60);
        @(posedge clk60MHz); #1;
        check("hold2.hp2", {1'b0, hp_player2}, 8'd20);
        step();
        check_all("hold3", 7'd100, 7'd0, 1'b1, 2'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hp_wind_ctl.md
# hp_wind_ctl

Game-state source for the HP/wind overlay: holds both players' hit points and the current wind, and updates them from hit and turn events raised by the projectile logic. It sits in the 60 MHz game-logic domain and drives the `hp_player1`, `hp_player2` and `wind` inputs of the HP/wind drawing stage in the VGA pipeline. It also flags end of game and the winner for the top-level game controller.

## Interface
- `HP_MAX`, default 7'd100. HP loaded on new game; must be 1..127.
- `LFSR_SEED`, default 16'hACE1. LFSR reset value; must be non-zero.
- `clk60MHz`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, synchronous and active-high.
- `new_game`  in  1  one-cycle pulse; (re)starts a game.
- `hit_p1`  in  1  one-cycle pulse; player 1 takes `damage`.
- `hit_p2`  in  1  one-cycle pulse; player 2 takes `damage`.
- `damage`  in  7  damage amount, sampled with the hit pulses.
- `turn_end`  in  1  one-cycle pulse; projectile resolved, new wind required.
- `hp_player1`  out  7  player 1 HP, registered.
- `hp_player2`  out  7  player 2 HP, registered.
- `wind`  out  3  wind; bit2 = direction (0 right, 1 left), [1:0] = magnitude 0..3. Registered.
- `game_over`  out  1  high while in OVER.
- `winner`  out  2  00 none, 01 player 1, 10 player 2, 11 draw. Registered.

## Operation
- FSM states: IDLE, PLAY, OVER. Reset puts the FSM in IDLE.
- Reset values:
  - `hp_player1` = `hp_player2` = `HP_MAX`
  - `wind` = 3'b000, `game_over` = 0, `winner` = 2'b00
  - LFSR = `LFSR_SEED`
- IDLE and OVER:
  - `new_game` → PLAY, both HP = `HP_MAX`, `wind` loaded with the wind source, `winner` = 00.
  - Hit pulses and `turn_end` are ignored.
- PLAY: HP updates
  - `hit_p1` sets `hp_player1` to `hp_player1 - damage`, saturating at 0 (8-bit compare, no wrap). `hit_p2` does the same for player 2.
  - Simultaneous `hit_p1` and `hit_p2` apply both in the same cycle.
  - `damage` = 0 leaves HP unchanged.
- PLAY: end of game
  - The game ends when the next-state HP of either player is 0. FSM goes to OVER on the same edge that writes the HP.
  - `winner`: 01 if only player 2 reaches 0, 10 if only player 1 reaches 0, 11 if both reach 0 on the same edge.
- PLAY: wind
  - `turn_end` loads `wind` from the wind source.
  - `turn_end` on the same cycle as a game-ending hit: the game ends and `wind` is still updated.
- `new_game` in PLAY restarts the game exactly as from IDLE; it overrides simultaneous hits and `turn_end`.
- LFSR
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Shifts left every cycle in every state except reset; the feedback bit (bit15^bit13^bit12^bit10) enters bit0.
  - The wind source value is the pre-shift `lfsr[2:0]` of the loading cycle.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Latency from a hit or `turn_end` pulse to the output update: 1 cycle.
- `game_over` rises on the same edge that writes the zero HP.
- Pulses longer than one cycle are treated as repeated events, one per cycle, e.g. repeated damage.
- `rst` has priority over every input at every edge; reset in the middle of a game returns all outputs to their reset values on the next edge.

## Configuration
- `HP_WIND_RANDOM_EN` defined: wind source is the LFSR, as described above.
- `HP_WIND_RANDOM_EN` undefined: the LFSR is not built. The wind source becomes a deterministic step:
  - `new_game` loads 3'b000.
  - Each `turn_end` increments the magnitude mod 4.
  - When the magnitude wraps 3→0, the direction bit toggles.
  - Sequence from `new_game`: 000, 001, 010, 011, 100, 101, …, 111, 000.

## Test plan
- Reset, then `new_game` on the first cycle after reset release, with `HP_WIND_RANDOM_EN` defined → next cycle: HP = 100/100, `wind` = 3'b001, `game_over` = 0.
- PLAY, `hit_p1` with `damage` = 30, four times → `hp_player1` reads 70, 40, 10, 0. `game_over` = 1 and `winner` = 10 in the same cycle as HP = 0. A further `hit_p2` leaves `hp_player2` at 100.
- PLAY with both HP = 20, `hit_p1` and `hit_p2` in the same cycle with `damage` = 20 → both HP = 0, `winner` = 11, state OVER.
- Without `HP_WIND_RANDOM_EN`: `new_game`, then six `turn_end` pulses → `wind` reads 001, 010, 011, 100, 101, 110.
- PLAY with HP 55/80, `rst` asserted for one cycle → next cycle: HP = 100/100, `wind` = 000, `game_over` = 0. `hit_p1` is then ignored until `new_game`.
- OVER, then `new_game` and `hit_p2` in the same cycle → state PLAY, HP = 100/100, `winner` = 00, hit ignored.
